// File: rtl/ntt_fifo_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : ntt_fifo_ctrl_pkg                                         |
// | Purpose  : Shared state encodings and size helpers for the NTT       |
// |            ping-pong FIFO sequencing controller.                     |
// | Contents : w_state_t, r_state_t, half_of(), cnt_width()              |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif

package ntt_fifo_ctrl_pkg;

   // Write-side sequencer states
   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_RUN  = 2'd1,
      W_FIN  = 2'd2
   } w_state_t;

   // Read-side sequencer states
   typedef enum logic [1:0] {
      R_IDLE = 2'd0,
      R_RUN  = 2'd1,
      R_FIN  = 2'd2
   } r_state_t;

   // Number of coefficient pairs per polynomial (N/2)
   function automatic int unsigned half_of(input int unsigned aw);
      return int'(1) << (aw - 1);
   endfunction

   // Beat counter width: indexes 0..HALF-1
   function automatic int unsigned cnt_width(input int unsigned aw);
      return aw - 1;
   endfunction

endpackage : ntt_fifo_ctrl_pkg

`default_nettype wire

// File: rtl/ntt_skid_buf2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : ntt_skid_buf2                                             |
// | Purpose  : Two-entry registered FIFO of {last, dA, dB} that absorbs  |
// |            the one-cycle read latency of the polynomial FIFO.        |
// | Ports    : clk, rst          - clock, synchronous active-high reset  |
// |            i_push, i_dA/dB,  - write one entry                       |
// |            i_last                                                    |
// |            i_pop             - consume head (ignored when empty)     |
// |            o_valid, o_dA/dB, - head entry                            |
// |            o_last                                                    |
// |            o_occ             - current occupancy 0..2                |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+

module ntt_skid_buf2 #(
   parameter int DATA_WIDTH = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_push,
   input  logic [DATA_WIDTH-1:0] i_dA,
   input  logic [DATA_WIDTH-1:0] i_dB,
   input  logic                  i_last,
   input  logic                  i_pop,
   output logic                  o_valid,
   output logic [DATA_WIDTH-1:0] o_dA,
   output logic [DATA_WIDTH-1:0] o_dB,
   output logic                  o_last,
   output logic [1:0]            o_occ
);

   logic [2*DATA_WIDTH:0] r_mem [0:1];
   logic                  r_wr_ptr;
   logic                  r_rd_ptr;
   logic [1:0]            r_occ;
   logic                  w_pop;

   assign w_pop = i_pop && (r_occ != 2'd0);

   // Storage carries no reset: an entry is only visible once occupancy counts it.
   always_ff @(posedge clk) begin
      if (i_push) begin
         r_mem[r_wr_ptr] <= {i_last, i_dA, i_dB};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_occ    <= 2'd0;
      end else begin
         if (i_push) begin
            r_wr_ptr <= ~r_wr_ptr;
         end
         if (w_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         case ({i_push, w_pop})
            2'b10:   r_occ <= r_occ + 2'd1;
            2'b01:   r_occ <= r_occ - 2'd1;
            default: r_occ <= r_occ;
         endcase
      end
   end

   assign o_valid                = (r_occ != 2'd0);
   assign {o_last, o_dA, o_dB}   = r_mem[r_rd_ptr];
   assign o_occ                  = r_occ;

endmodule : ntt_skid_buf2

`default_nettype wire

// File: rtl/ntt_fifo_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : ntt_fifo_ctrl                                             |
// | Purpose  : Sequences one ping-pong NTT polynomial FIFO: upstream     |
// |            pairs become slot writes, slot reads become a downstream  |
// |            pair stream, with per-polynomial finish pulses.           |
// | Ports    : clk, rst                 - clock, sync active-high reset  |
// |            in_valid/in_ready,       - upstream pair handshake        |
// |            in_dA/in_dB                                               |
// |            src_addrA/B, src_dA/B,   - FIFO write port                |
// |            src_wr_en, src_wr_finish,                                 |
// |            src_full                                                  |
// |            snk_addrA/B, snk_rd_en,  - FIFO read port                 |
// |            snk_dA/B, snk_rd_finish,                                  |
// |            snk_empty                                                 |
// |            out_valid/out_ready,     - downstream pair handshake      |
// |            out_dA/out_dB, out_last                                   |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+

module ntt_fifo_ctrl
   import ntt_fifo_ctrl_pkg::*;
#(
   parameter int ADDR_WIDTH = `ADDR_WIDTH,
   parameter int DATA_WIDTH = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   // upstream
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_dA,
   input  logic [DATA_WIDTH-1:0] in_dB,
   // FIFO source (write) side
   output logic [ADDR_WIDTH-1:0] src_addrA,
   output logic [ADDR_WIDTH-1:0] src_addrB,
   output logic [DATA_WIDTH-1:0] src_dA,
   output logic [DATA_WIDTH-1:0] src_dB,
   output logic                  src_wr_en,
   output logic                  src_wr_finish,
   input  logic                  src_full,
   // FIFO sink (read) side
   output logic [ADDR_WIDTH-1:0] snk_addrA,
   output logic [ADDR_WIDTH-1:0] snk_addrB,
   output logic                  snk_rd_en,
   input  logic [DATA_WIDTH-1:0] snk_dA,
   input  logic [DATA_WIDTH-1:0] snk_dB,
   output logic                  snk_rd_finish,
   input  logic                  snk_empty,
   // downstream
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_dA,
   output logic [DATA_WIDTH-1:0] out_dB,
   output logic                  out_last
);

   localparam int unsigned         c_CW   = cnt_width(ADDR_WIDTH);
   localparam int unsigned         c_HALF = half_of(ADDR_WIDTH);
   localparam logic [c_CW-1:0]     c_LAST = c_CW'(c_HALF - 1);
   localparam logic [c_CW-1:0]     c_ONE  = c_CW'(1);

   // ------------------------------------------------------------------
   // Common
   // ------------------------------------------------------------------
   logic r_rst_q;
   logic w_live;

   always_ff @(posedge clk) begin
      r_rst_q <= rst;
   end

   // Handshakes stay closed during reset and the cycle after it, so the
   // FIFO (reset by the same rst) has settled before the first transfer.
   assign w_live = !rst && !r_rst_q;

   // ------------------------------------------------------------------
   // Write side
   // ------------------------------------------------------------------
   w_state_t          r_wstate;
   logic [c_CW-1:0]   r_wcnt;
   logic              w_in_ready;
   logic              w_wr_acc;

   always_comb begin
      w_in_ready = 1'b0;
      case (r_wstate)
         W_IDLE:  w_in_ready = !src_full;
         W_RUN:   w_in_ready = 1'b1;    // slot already claimed
         default: w_in_ready = 1'b0;
      endcase
      w_in_ready = w_in_ready && w_live;
   end

   assign w_wr_acc = in_valid && w_in_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wstate <= W_IDLE;
         r_wcnt   <= '0;
      end else begin
         case (r_wstate)
            W_IDLE, W_RUN: begin
               if (w_wr_acc) begin
                  if (r_wcnt == c_LAST) begin
                     r_wstate <= W_FIN;
                     r_wcnt   <= '0;
                  end else begin
                     r_wstate <= W_RUN;
                     r_wcnt   <= r_wcnt + c_ONE;
                  end
               end
            end
            W_FIN: begin
               r_wstate <= W_IDLE;
            end
            default: begin
               r_wstate <= W_IDLE;
               r_wcnt   <= '0;
            end
         endcase
      end
   end

   assign in_ready      = w_in_ready;
   assign src_wr_en     = w_wr_acc;
   assign src_addrA     = {1'b0, r_wcnt};
   assign src_addrB     = {1'b1, r_wcnt};
   assign src_dA        = in_dA;
   assign src_dB        = in_dB;
   assign src_wr_finish = (r_wstate == W_FIN) && !rst;

   // ------------------------------------------------------------------
   // Read side
   // ------------------------------------------------------------------
   r_state_t          r_rstate;
   logic [c_CW-1:0]   r_rcnt;
   logic              r_inflight;
   logic              r_issue_last;
   logic              w_rd_allowed;
   logic              w_room;
   logic              w_issue;
   logic              w_pop;
   logic [2:0]        w_pend;
   logic [1:0]        w_occ;
   logic              w_skid_valid;
   logic              w_skid_last;

   always_comb begin
      w_rd_allowed = 1'b0;
      case (r_rstate)
         R_IDLE:  w_rd_allowed = !snk_empty;
         R_RUN:   w_rd_allowed = 1'b1;
         default: w_rd_allowed = 1'b0;
      endcase
   end

   // Issue only if the read (plus any read whose data lands next cycle)
   // is guaranteed a skid slot: occ + inflight - pop < 2.
   assign w_pend  = {1'b0, w_occ} + {2'b00, r_inflight};
   assign w_room  = w_pend < (3'd2 + {2'b00, w_pop});
   assign w_issue = w_rd_allowed && w_room && w_live;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rstate     <= R_IDLE;
         r_rcnt       <= '0;
         r_inflight   <= 1'b0;
         r_issue_last <= 1'b0;
      end else begin
         r_inflight   <= w_issue;
         r_issue_last <= w_issue && (r_rcnt == c_LAST);
         case (r_rstate)
            R_IDLE, R_RUN: begin
               if (w_issue) begin
                  if (r_rcnt == c_LAST) begin
                     r_rstate <= R_FIN;
                     r_rcnt   <= '0;
                  end else begin
                     r_rstate <= R_RUN;
                     r_rcnt   <= r_rcnt + c_ONE;
                  end
               end
            end
            R_FIN: begin
               // snk_empty is next looked at in R_IDLE, after the FIFO
               // has advanced its read pointer on this pulse.
               r_rstate <= R_IDLE;
            end
            default: begin
               r_rstate <= R_IDLE;
               r_rcnt   <= '0;
            end
         endcase
      end
   end

   assign snk_rd_en     = w_issue;
   assign snk_addrA     = {1'b0, r_rcnt};
   assign snk_addrB     = {1'b1, r_rcnt};
   assign snk_rd_finish = (r_rstate == R_FIN) && !rst;

   // Read data arrives one cycle after the strobe; capture it then.
   ntt_skid_buf2 #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_skid (
      .clk     (clk),
      .rst     (rst),
      .i_push  (r_inflight),
      .i_dA    (snk_dA),
      .i_dB    (snk_dB),
      .i_last  (r_issue_last),
      .i_pop   (w_pop),
      .o_valid (w_skid_valid),
      .o_dA    (out_dA),
      .o_dB    (out_dB),
      .o_last  (w_skid_last),
      .o_occ   (w_occ)
   );

   assign out_valid = w_skid_valid && !rst;
   assign out_last  = w_skid_last && out_valid;
   assign w_pop     = out_valid && out_ready;

endmodule : ntt_fifo_ctrl

`default_nettype wire

// File: tb/tb_ntt_fifo_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_ntt_fifo_ctrl                                          |
// | Purpose  : Self-checking bench for ntt_fifo_ctrl with a behavioural  |
// |            two-slot ping-pong FIFO (ADDR_WIDTH=3, DATA_WIDTH=16).    |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+

module tb_ntt_fifo_ctrl;

   localparam int AW = 3;
   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid, in_ready;
   logic [DW-1:0] in_dA, in_dB;
   logic [AW-1:0] src_addrA, src_addrB, snk_addrA, snk_addrB;
   logic [DW-1:0] src_dA, src_dB, snk_dA, snk_dB, out_dA, out_dB;
   logic          src_wr_en, src_wr_finish, src_full;
   logic          snk_rd_en, snk_rd_finish, snk_empty;
   logic          out_valid, out_ready, out_last;

   always #5 clk = ~clk;

   ntt_fifo_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_dA(in_dA), .in_dB(in_dB),
      .src_addrA(src_addrA), .src_addrB(src_addrB), .src_dA(src_dA), .src_dB(src_dB),
      .src_wr_en(src_wr_en), .src_wr_finish(src_wr_finish), .src_full(src_full),
      .snk_addrA(snk_addrA), .snk_addrB(snk_addrB), .snk_rd_en(snk_rd_en),
      .snk_dA(snk_dA), .snk_dB(snk_dB), .snk_rd_finish(snk_rd_finish), .snk_empty(snk_empty),
      .out_valid(out_valid), .out_ready(out_ready), .out_dA(out_dA), .out_dB(out_dB),
      .out_last(out_last)
   );

   // ---------------- behavioural myFIFO_NTT, POINTER_WIDTH=1 ----------------
   logic [DW-1:0] mem [0:1][0:7];
   logic          m_wptr, m_rptr;
   int            m_cnt;
   bit            force_ne;

   always @(posedge clk) begin
      if (rst) begin
         m_wptr <= 1'b0;
         m_rptr <= 1'b0;
         m_cnt  <= 0;
      end else begin
         if (src_wr_en) begin
            mem[m_wptr][src_addrA] <= src_dA;
            mem[m_wptr][src_addrB] <= src_dB;
         end
         if (snk_rd_en) begin
            snk_dA <= mem[m_rptr][snk_addrA];
            snk_dB <= mem[m_rptr][snk_addrB];
         end
         if (src_wr_finish) m_wptr <= ~m_wptr;
         if (snk_rd_finish) m_rptr <= ~m_rptr;
         m_cnt <= m_cnt + (src_wr_finish ? 1 : 0) - (snk_rd_finish ? 1 : 0);
      end
   end

   assign src_full  = (m_cnt >= 2);
   assign snk_empty = (m_cnt == 0) && !force_ne;

   // ---------------- bench state ----------------
   int errors = 0, checks = 0;
   int cyc = 0, p = 0, k = 0, tx_left = 0, pidx = 0;
   int n_wfin = 0, n_rfin = 0, n_pop = 0, n_last = 0, wr_beats = 0, rd_issues = 0;
   bit gen_on = 1'b0, pat_on = 1'b0, rdy_hold = 1'b0;
   logic [5:0]  pat;
   logic [32:0] sb [$];
   int wfin_cyc [$];
   int rfin_cyc [$];

   logic          s_in_ready, s_wr_en, s_wr_fin, s_rd_en, s_rd_fin;
   logic          s_out_valid, s_out_last, s_src_full;
   logic [AW-1:0] s_addrA, s_addrB, s_snk_addrA;
   logic [AW-1:0] s_snk_addrB;
   logic [DW-1:0] s_src_dA;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive();
      in_valid  = gen_on && (tx_left > 0);
      in_dA     = 16'(p * 16 + k);
      in_dB     = 16'(p * 16 + k + 100);
      out_ready = pat_on ? pat[pidx % 6] : rdy_hold;
      pidx++;
   endtask

   // One clock: sample at the falling edge, score, then drive after the rise.
   task automatic tick();
      @(negedge clk);
      cyc++;
      s_in_ready  = in_ready;   s_wr_en  = src_wr_en;  s_wr_fin = src_wr_finish;
      s_rd_en     = snk_rd_en;  s_rd_fin = snk_rd_finish;
      s_out_valid = out_valid;  s_out_last = out_last; s_src_full = src_full;
      s_addrA     = src_addrA;  s_addrB  = src_addrB;  s_src_dA = src_dA;
      s_snk_addrA = snk_addrA;  s_snk_addrB = snk_addrB;
      if (rst) begin
         wr_beats  = 0;
         rd_issues = 0;
      end else begin
         if (src_wr_en) wr_beats++;
         if (snk_rd_en) rd_issues++;
         if (src_wr_finish) begin
            chk("beats_per_wr_finish", wr_beats, 4);
            wr_beats = 0; n_wfin++; wfin_cyc.push_back(cyc);
         end
         if (snk_rd_finish) begin
            chk("issues_per_rd_finish", rd_issues, 4);
            rd_issues = 0; n_rfin++; rfin_cyc.push_back(cyc);
         end
         chk("skid_occ_le2", (dut.u_skid.o_occ <= 2'd2), 1);
         if (out_valid && out_ready) begin
            chk("sb_nonempty_on_pop", (sb.size() != 0), 1);
            if (sb.size() != 0) chk("out_pair", {out_last, out_dA, out_dB}, sb.pop_front());
            n_pop++;
            if (out_last) n_last++;
         end
         if (in_valid && in_ready) begin
            sb.push_back({(k == 3), in_dA, in_dB});
            tx_left--;
            k++;
            if (k == 4) begin
               k = 0;
               p++;
            end
         end
      end
      @(posedge clk);
      #1;
      drive();
   endtask

   task automatic drain(input string tag, input int budget);
      bit done = 1'b0;
      for (int i = 0; i < budget; i++) begin
         tick();
         if (sb.size() == 0 && tx_left == 0) begin
            done = 1'b1;
            break;
         end
      end
      chk(tag, done, 1);
      for (int i = 0; i < 4; i++) tick();
   endtask

   initial begin
      int base_pop, base_last, seen;
      bit done;
      pat      = 6'b101001;        // out_ready 1,0,0,1,0,1 (bit 0 first)
      rst      = 1'b1;
      force_ne = 1'b1;
      gen_on   = 1'b1;
      tx_left  = 4;
      drive();

      // ---- 1: reset with in_valid=1 and snk_empty=0 ----
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rst_in_ready",  s_in_ready, 0);
         chk("rst_wr_en",     s_wr_en, 0);
         chk("rst_rd_en",     s_rd_en, 0);
         chk("rst_out_valid", s_out_valid, 0);
      end
      chk("rst_addrA", s_addrA, 0);
      chk("rst_addrB", s_addrB, 4);
      chk("rst_finish", {s_wr_fin, s_rd_fin, s_out_last}, 0);
      rst = 1'b0;
      tick();
      chk("post_rst_in_ready", s_in_ready, 0);
      chk("post_rst_rd_en",    s_rd_en, 0);
      chk("post_rst_finish",   {s_wr_fin, s_rd_fin}, 0);
      force_ne = 1'b0;

      // ---- 2: single polynomial write, out_ready=0 ----
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("wr_en_beat", s_wr_en, 1);
         chk("wr_addrA", s_addrA, i);
         chk("wr_addrB", s_addrB, 4 + i);
         chk("wr_dA", s_src_dA, i);
      end
      tick();
      chk("wr_finish_pulse", {s_wr_fin, s_in_ready, s_wr_en}, 3'b100);
      tick();
      chk("wr_finish_single", s_wr_fin, 0);
      chk("idle_in_ready", s_in_ready, !s_src_full);
      chk("wr_finish_count", n_wfin, 1);

      // ---- 3: fill both slots ----
      tx_left = 4;
      drive();
      done = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (n_wfin == 2) begin
            done = 1'b1;
            break;
         end
      end
      chk("fill_timeout", done, 1);
      tick();
      chk("fill_full", s_src_full, 1);
      chk("fill_in_ready", s_in_ready, 0);
      tx_left = 4;
      drive();
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (s_wr_en) seen++;
      end
      chk("held_no_wr_en", seen, 0);
      chk("held_in_ready", s_in_ready, 0);

      // ---- 4: stream with out_ready=1 ----
      rdy_hold = 1'b1;
      tx_left  = tx_left + 8;
      drive();
      drain("stream_timeout", 300);
      chk("stream_pops", n_pop, 20);
      chk("stream_lasts", n_last, 5);

      // throughput from an empty FIFO: finishes every 5 cycles on both sides
      wfin_cyc.delete();
      rfin_cyc.delete();
      tx_left = 12;
      drive();
      drain("rate_timeout", 200);
      chk("rate_wfin_n", wfin_cyc.size(), 3);
      chk("rate_rfin_n", rfin_cyc.size(), 3);
      if (wfin_cyc.size() >= 3 && rfin_cyc.size() >= 3) begin
         chk("rate_w01", wfin_cyc[1] - wfin_cyc[0], 5);
         chk("rate_w12", wfin_cyc[2] - wfin_cyc[1], 5);
         chk("rate_r01", rfin_cyc[1] - rfin_cyc[0], 5);
         chk("rate_r12", rfin_cyc[2] - rfin_cyc[1], 5);
      end

      // ---- 5: downstream backpressure ----
      base_pop  = n_pop;
      base_last = n_last;
      pat_on    = 1'b1;
      pidx      = 0;
      tx_left   = 12;
      drive();
      drain("bp_timeout", 400);
      chk("bp_pops", n_pop - base_pop, 12);
      chk("bp_lasts", n_last - base_last, 3);
      pat_on = 1'b0;

      // ---- 6: reset mid-read ----
      base_pop = n_pop;
      tx_left  = 4;
      drive();
      done = 1'b0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (n_pop - base_pop == 2) begin
            done = 1'b1;
            break;
         end
      end
      chk("midrst_timeout", done, 1);
      rst      = 1'b1;
      rdy_hold = 1'b0;
      tx_left  = 0;
      drive();
      tick();
      chk("midrst_no_finish", {s_wr_fin, s_rd_fin}, 0);
      chk("midrst_out_valid_in_rst", s_out_valid, 0);
      rst = 1'b0;
      tick();
      chk("midrst_out_valid", s_out_valid, 0);
      chk("midrst_no_rd_finish", s_rd_fin, 0);
      sb.delete();
      if (k != 0) begin
         k = 0;
         p++;
      end
      rdy_hold = 1'b1;
      tx_left  = 4;
      drive();
      done = 1'b0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (s_rd_en) begin
            done = 1'b1;
            break;
         end
      end
      chk("restart_timeout", done, 1);
      chk("restart_addrA", s_snk_addrA, 0);
      chk("restart_addrB", s_snk_addrB, 4);
      drain("restart_drain", 100);
      chk("final_sb_empty", sb.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_ntt_fifo_ctrl

`default_nettype wire

// File: doc/ntt_fifo_ctrl.md
# ntt_fifo_ctrl

Sequencing controller for the ping-pong NTT polynomial FIFO (`myFIFO_NTT`). It turns an upstream valid/ready stream of coefficient pairs into slot writes on the FIFO source port, and FIFO slot reads into a downstream valid/ready stream. It generates the A/B address pairs, write/read enables and the per-polynomial finish pulses on both sides. It sits between the NTT butterfly stages and each FIFO instance.

## Interface
- `ADDR_WIDTH`, default `` `ADDR_WIDTH ``: polynomial address width; must be ≥2; N=2^ADDR_WIDTH, HALF=N/2.
- `DATA_WIDTH`, default 64: coefficient width.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1 / `in_ready` out 1: upstream pair handshake.
- `in_dA`, `in_dB` in DATA_WIDTH: upstream pair (coeff i, coeff i+HALF).
- `src_addrA`, `src_addrB` out ADDR_WIDTH: FIFO write addresses.
- `src_dA`, `src_dB` out DATA_WIDTH: FIFO write data.
- `src_wr_en` out 1: write strobe.
- `src_wr_finish` out 1: 1-cycle pulse; FIFO advances its write pointer.
- `src_full` in 1: FIFO has no free slot.
- `snk_addrA`, `snk_addrB` out ADDR_WIDTH: FIFO read addresses.
- `snk_rd_en` out 1: read strobe.
- `snk_dA`, `snk_dB` in DATA_WIDTH: read data, valid 1 cycle after `snk_rd_en`.
- `snk_rd_finish` out 1: 1-cycle pulse; FIFO advances its read pointer.
- `snk_empty` in 1: FIFO has no full slot.
- `out_valid` out 1 / `out_ready` in 1: downstream handshake.
- `out_dA`, `out_dB` out DATA_WIDTH: downstream pair.
- `out_last` out 1: marks the pair with index HALF-1.

## Operation
- Beat index k is in 0..HALF-1. addrA = {1'b0,k}; addrB = {1'b1,k}. Counters are ADDR_WIDTH-1 bits wide and wrap to 0 only through the FSM, never by overflow.
- Write FSM:
  - W_IDLE: in_ready = !src_full.
  - W_RUN: in_ready = 1. The slot is already claimed, so src_full is ignored.
  - W_FIN: in_ready = 0, src_wr_finish = 1.
  - Each accepted beat asserts src_wr_en combinationally, with src_d* = in_d* and addresses taken from wcnt. wcnt then increments.
  - Transitions: W_IDLE→W_RUN on the first accept. An accept at wcnt=HALF-1 goes to W_FIN from either state. W_FIN→W_IDLE unconditionally. wcnt returns to 0 at W_FIN.
  - If in_valid is low mid-polynomial, the FSM holds.
- Read FSM:
  - R_IDLE: issue allowed if !snk_empty.
  - R_RUN: issue allowed.
  - R_FIN: no issue; snk_rd_finish = 1.
  - Issue condition: allowed && (occ + inflight − pop) < 2. occ is the 2-entry skid-buffer occupancy, inflight is the previous cycle's snk_rd_en, and pop = out_valid && out_ready.
  - Issue at rcnt=HALF-1 moves to R_FIN. R_FIN is entered the cycle after the last issue, while the last data is being captured. R_FIN→R_IDLE. rcnt resets to 0.
  - snk_empty is re-examined only in R_IDLE, i.e. after the pointer update.
- The skid buffer captures snk_d* in the cycle after issue, tagged with last = (issued rcnt == HALF-1).
- The skid buffer is FIFO-ordered. Data is never dropped or duplicated.
- Reset mid-operation: both FSMs go to IDLE, counters go to 0, and the skid buffer plus inflight are cleared. The partial polynomial is discarded; the FIFO is reset by the same `rst`. No finish pulse is emitted.

## Timing
- Reset values (while rst=1 and the cycle after): in_ready, src_wr_en, src_wr_finish, snk_rd_en, snk_rd_finish, out_valid, out_last = 0. All addresses = 0/HALF.
- Write path: zero latency. A beat accepted in cycle t is written in cycle t. src_wr_finish is asserted in cycle t+1 after the last beat.
- Read path: snk_rd_en at t, capture at t+1, out_valid at t+2 at the earliest.
- Throughput with continuous valid/ready:
  - Write: HALF beats per HALF+1 cycles.
  - Read: HALF beats per HALF+1 cycles, plus 1 empty-check cycle if the FIFO refills late.
- Simultaneous src_wr_finish and snk_rd_finish are independent and both legal.

## Structure
- `ntt_fifo_ctrl_pkg`: the w_state_t {W_IDLE,W_RUN,W_FIN} and r_state_t {R_IDLE,R_RUN,R_FIN} enums, and the HALF/counter-width helper functions.
- Sub-module `ntt_skid_buf2`: a 2-entry registered buffer of {dA,dB,last} with push/pop/occ ports.
- Top level: two FSMs plus counters, roughly 200–300 lines total.

## Test plan
All scenarios use ADDR_WIDTH=3 (HALF=4), DATA_WIDTH=16, and a `myFIFO_NTT` with POINTER_WIDTH=1.
1. Reset: rst=1 for 3 cycles with in_valid=1 and snk_empty=0 → in_ready, src_wr_en, snk_rd_en and out_valid are all 0, and src_addrB=4.
2. Single write: dA=0..3, dB=100..103, out_ready=0 → src_wr_en for 4 cycles with addrA 0,1,2,3 and addrB 4,5,6,7. This is followed by exactly one src_wr_finish pulse, then in_ready=!src_full.
3. Fill: two polynomials with out_ready=0 → after the second src_wr_finish, src_full=1 and in_ready=0. A third polynomial is held with no src_wr_en.
4. Stream: in_valid=1 and out_ready=1 continuously with 3 polynomials → out pairs are (0,100)…(3,103) in order, with out_last=1 exactly on every 4th beat. Each polynomial takes 5 cycles per 4 beats on both sides.
5. Backpressure: out_ready pattern 1,0,0,1,0,1… → the output sequence is identical to scenario 4, the skid buffer never exceeds occ=2, and snk_rd_finish comes only after the 4th capture.
6. Reset mid-read: assert rst after 2 output beats → out_valid=0 on the next cycle, no snk_rd_finish, and the read restarts from addrA=0 once snk_empty=0 again.
